// File: rtl/debug_display_pkg.sv
// Shared types and seven-segment constants for the debug display controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Segment codes are stored active-low in gfedcba order (bit 0 = segment a).
package debug_display_pkg;

    typedef enum logic [1:0] {
        DISP_UDEC  = 2'b00,
        DISP_SDEC  = 2'b01,
        DISP_HEX   = 2'b10,
        DISP_FLAGS = 2'b11
    } disp_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_ENCODE
    } disp_state_t;

    localparam logic [6:0] SEG_CODE [16] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000,  // 9
        7'b0001000,  // A
        7'b0000011,  // b
        7'b1000110,  // C
        7'b0100001,  // d
        7'b0000110,  // E
        7'b0001110   // F
    };

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

endpackage

// File: rtl/debug_display_ctrl_seg7_encode.sv
// One seven-segment digit: nibble glyph, or blank/minus override, output polarity applied.
// Latency: combinational.
// Backpressure: none.
//
// Ports: nibble (digit value 0..F), blank (all segments off, highest priority),
//        minus (centre bar only), seg (gfedcba, polarity set by ACTIVE_LOW).
module seg7_encode
    import debug_display_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic [3:0] nibble,
    input  logic       blank,
    input  logic       minus,
    output logic [6:0] seg
);

    logic [6:0] code_al;

    always_comb begin
        if (blank) begin
            code_al = SEG_BLANK;
        end else if (minus) begin
            code_al = SEG_MINUS;
        end else begin
            code_al = SEG_CODE[nibble];
        end
        seg = ACTIVE_LOW ? code_al : ~code_al;
    end

endmodule

// File: rtl/debug_display_ctrl.sv
// Renders a debug word on NUM_DIGITS seven-segment digits as udec/sdec/hex/NZCV flags.
// Latency: trigger to seg_o update is DATA_W+2 cycles (decimal) or 2 cycles (hex/flags).
// Backpressure: none; input changes and update_i while busy_o are dropped, re-compared in IDLE.
//
// Ports: clk, rst (sync, active-high), value_i, mode_i, update_i (force reconversion),
//        seg_o (digit k at [7k+6:7k]), busy_o, valid_o, overflow_o.
module debug_display_ctrl
    import debug_display_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int NUM_DIGITS = 6,
    parameter bit ACTIVE_LOW = 1'b1,
    parameter bit BLANK_LZ   = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_W-1:0]       value_i,
    input  logic [1:0]              mode_i,
    input  logic                    update_i,
    output logic [7*NUM_DIGITS-1:0] seg_o,
    output logic                    busy_o,
    output logic                    valid_o,
    output logic                    overflow_o
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [6:0] BLANK_OUT = ACTIVE_LOW ? SEG_BLANK : ~SEG_BLANK;

    disp_state_t       state;
    logic [DATA_W-1:0] last_value;
    disp_mode_t        last_mode;
    logic              stale;      // stored value/mode invalid: forces one conversion after reset
    logic [DATA_W-1:0] bin;
    // Holds BCD digits in decimal modes, and the final digit nibbles directly in hex/flags modes,
    // so the encode stage treats every mode the same way.
    logic [BCD_W-1:0]  bcd;
    logic              sign;
    logic              sticky;
    logic [CNT_W-1:0]  cnt;

    logic [BCD_W-1:0]         bcd_adj;
    logic [DATA_W+BCD_W-1:0]  hex_ext;
    logic [BCD_W-1:0]         flags_nib;
    logic [NUM_DIGITS-1:0][3:0] dig_nib;
    logic [NUM_DIGITS-1:0]    dig_blank;
    logic [NUM_DIGITS-1:0]    dig_minus;
    logic                     zero_run;
    logic [7*NUM_DIGITS-1:0]  seg_next;

    // Double-dabble correction: nibbles >= 5 get +3 so the following shift carries correctly.
    always_comb begin
        bcd_adj = bcd;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (bcd[4*k +: 4] >= 4'd5) begin
                bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
            end
        end
    end

    // Zero-extending by a full display width lets the hex digits and the "did not fit" bits
    // be sliced the same way whether DATA_W is wider or narrower than the display.
    always_comb begin
        hex_ext   = {{BCD_W{1'b0}}, last_value};
        flags_nib = '0;
        for (int k = 0; k < 4; k++) begin
            flags_nib[4*k] = last_value[DATA_W-4+k];
        end
    end

    // Per-digit glyph control. Leading-zero detection scans from the top down; in signed mode
    // the top digit is reserved for the sign and excluded from the scan.
    always_comb begin
        zero_run  = 1'b1;
        dig_nib   = '0;
        dig_blank = '0;
        dig_minus = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            if (last_mode == DISP_SDEC && k == NUM_DIGITS - 1) begin
                dig_nib[k]   = 4'd0;
                dig_minus[k] = sign;
                dig_blank[k] = BLANK_LZ && !sign;
            end else begin
                dig_nib[k]   = bcd[4*k +: 4];
                zero_run     = zero_run && (bcd[4*k +: 4] == 4'd0);
                dig_blank[k] = BLANK_LZ && (last_mode != DISP_FLAGS) && (k != 0) && zero_run;
            end
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        seg7_encode #(
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_seg7 (
            .nibble (dig_nib[g]),
            .blank  (dig_blank[g]),
            .minus  (dig_minus[g]),
            .seg    (seg_next[7*g +: 7])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            last_value <= '0;
            last_mode  <= DISP_UDEC;
            stale      <= 1'b1;
            bin        <= '0;
            bcd        <= '0;
            sign       <= 1'b0;
            sticky     <= 1'b0;
            cnt        <= '0;
            seg_o      <= {NUM_DIGITS{BLANK_OUT}};
            busy_o     <= 1'b0;
            valid_o    <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (update_i || stale || (value_i != last_value) || (mode_i != last_mode)) begin
                        last_value <= value_i;
                        last_mode  <= disp_mode_t'(mode_i);
                        stale      <= 1'b0;
                        busy_o     <= 1'b1;
                        state      <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    sign   <= 1'b0;
                    sticky <= 1'b0;
                    cnt    <= CNT_W'(DATA_W);
                    bcd    <= '0;
                    case (last_mode)
                        DISP_UDEC: begin
                            bin   <= last_value;
                            state <= ST_SHIFT;
                        end
                        DISP_SDEC: begin
                            // DATA_W-bit negation is exact for the most negative value as an unsigned magnitude.
                            bin   <= last_value[DATA_W-1] ? (~last_value + 1'b1) : last_value;
                            sign  <= last_value[DATA_W-1];
                            state <= ST_SHIFT;
                        end
                        DISP_HEX: begin
                            bcd    <= hex_ext[BCD_W-1:0];
                            sticky <= |hex_ext[DATA_W+BCD_W-1:BCD_W];
                            state  <= ST_ENCODE;
                        end
                        default: begin
                            bcd   <= flags_nib;
                            state <= ST_ENCODE;
                        end
                    endcase
                end
                ST_SHIFT: begin
                    bcd <= {bcd_adj[BCD_W-2:0], bin[DATA_W-1]};
                    bin <= {bin[DATA_W-2:0], 1'b0};
                    if (bcd_adj[BCD_W-1]) begin
                        sticky <= 1'b1;
                    end
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state <= ST_ENCODE;
                    end
                end
                ST_ENCODE: begin
                    seg_o      <= seg_next;
                    valid_o    <= 1'b1;
                    // Signed magnitude must also fit below the sign digit.
                    overflow_o <= sticky | ((last_mode == DISP_SDEC) && (bcd[BCD_W-1 -: 4] != 4'd0));
                    busy_o     <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_debug_display_ctrl.sv
module tb_debug_display_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] value;
    logic [1:0]  mode;
    logic        update;

    logic [41:0] seg0, seg1;
    logic        busy0, busy1, valid0, valid1, ovf0, ovf1;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    debug_display_ctrl #(.DATA_W(32), .NUM_DIGITS(6), .ACTIVE_LOW(1'b1), .BLANK_LZ(1'b0)) dut0 (
        .clk(clk), .rst(rst), .value_i(value), .mode_i(mode), .update_i(update),
        .seg_o(seg0), .busy_o(busy0), .valid_o(valid0), .overflow_o(ovf0)
    );

    debug_display_ctrl #(.DATA_W(32), .NUM_DIGITS(6), .ACTIVE_LOW(1'b1), .BLANK_LZ(1'b1)) dut1 (
        .clk(clk), .rst(rst), .value_i(value), .mode_i(mode), .update_i(update),
        .seg_o(seg1), .busy_o(busy1), .valid_o(valid1), .overflow_o(ovf1)
    );

    // ---------------- reference model ----------------
    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0:  return 7'b1000000;
            1:  return 7'b1111001;
            2:  return 7'b0100100;
            3:  return 7'b0110000;
            4:  return 7'b0011001;
            5:  return 7'b0010010;
            6:  return 7'b0000010;
            7:  return 7'b1111000;
            8:  return 7'b0000000;
            9:  return 7'b0010000;
            10: return 7'b0001000;
            11: return 7'b0000011;
            12: return 7'b1000110;
            13: return 7'b0100001;
            14: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    function automatic void model(input logic [31:0] v, input logic [1:0] m, input bit blz,
                                  output logic [41:0] seg, output bit ovf);
        longint unsigned mag, p;
        int dig [6];
        bit neg;
        int top, msd;
        logic [6:0] code;
        neg = 1'b0;
        ovf = 1'b0;
        mag = 0;
        for (int k = 0; k < 6; k++) dig[k] = 0;
        case (m)
            2'd0, 2'd1: begin
                neg = (m == 2'd1) && v[31];
                mag = neg ? (64'h1_0000_0000 - {32'd0, v}) : {32'd0, v};
                ovf = (m == 2'd0) ? (mag >= 1000000) : (mag >= 100000);
                p = 1;
                for (int k = 0; k < 6; k++) begin
                    dig[k] = int'((mag / p) % 10);
                    p = p * 10;
                end
            end
            2'd2: begin
                for (int k = 0; k < 6; k++) dig[k] = int'((v >> (4*k)) & 32'hF);
                ovf = (v >> 24) != 0;
            end
            default: begin
                for (int k = 0; k < 4; k++) dig[k] = int'(v[28+k]);
            end
        endcase
        top = (m == 2'd1) ? 4 : 5;
        msd = 0;
        for (int k = 0; k <= top; k++) if (dig[k] != 0) msd = k;
        for (int k = 0; k < 6; k++) begin
            code = seg_of(dig[k]);
            if (blz && m != 2'd3 && k > msd && k <= top) code = 7'b1111111;
            if (m == 2'd1 && k == 5) code = neg ? 7'b0111111 : (blz ? 7'b1111111 : seg_of(0));
            seg[7*k +: 7] = code;
        end
    endfunction

    // Transaction-level timing: an idle controller picks up a changed/forced input on the next
    // edge, and the display changes 34 (decimal) or 2 (hex/flags) edges later.
    int          m_rem;
    bit          m_stale, m_busy, m_valid, m_ovf;
    logic [41:0] m_seg0, m_seg1;
    logic [31:0] m_val;
    logic [1:0]  m_mode;

    always @(posedge clk) begin
        bit o0, o1;
        if (rst) begin
            m_rem = 0; m_stale = 1'b1; m_busy = 1'b0; m_valid = 1'b0; m_ovf = 1'b0;
            m_seg0 = {42{1'b1}}; m_seg1 = {42{1'b1}}; m_val = '0; m_mode = '0;
        end else if (m_rem > 0) begin
            m_rem = m_rem - 1;
            if (m_rem == 0) begin
                model(m_val, m_mode, 1'b0, m_seg0, o0);
                model(m_val, m_mode, 1'b1, m_seg1, o1);
                m_ovf = o0; m_valid = 1'b1; m_busy = 1'b0;
            end
        end else if (update || m_stale || value != m_val || mode != m_mode) begin
            m_val = value; m_mode = mode; m_stale = 1'b0; m_busy = 1'b1;
            m_rem = mode[1] ? 2 : 34;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy0", 64'(busy0), 64'(m_busy));
            check("busy1", 64'(busy1), 64'(m_busy));
            check("valid0", 64'(valid0), 64'(m_valid));
            check("valid1", 64'(valid1), 64'(m_valid));
            check("ovf0", 64'(ovf0), 64'(m_ovf));
            check("ovf1", 64'(ovf1), 64'(m_ovf));
            check("seg0", 64'(seg0), 64'(m_seg0));
            check("seg1", 64'(seg1), 64'(m_seg1));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy0 && n < 100) begin
            n++;
            cyc(1);
        end
    endtask

    task automatic run(input logic [31:0] v, input logic [1:0] m, input bit upd, output int n);
        value = v; mode = m; update = upd;
        cyc(1);
        update = 1'b0;
        wait_idle(n);
    endtask

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000,
                           S4 = 7'b0011001, S5 = 7'b0010010, S6 = 7'b0000010, S7 = 7'b1111000,
                           S9 = 7'b0010000, SA = 7'b0001000, SB = 7'b0000011, SD = 7'b0100001,
                           SE = 7'b0000110, SF = 7'b0001110, SM = 7'b0111111, SX = 7'b1111111;

    initial begin
        int n;
        rst = 1'b1; value = '0; mode = 2'b00; update = 1'b0;
        cyc(2);
        chk_en = 1'b1;
        check("rst_seg", 64'(seg0), 64'({SX, SX, SX, SX, SX, SX}));
        check("rst_busy", 64'(busy0), 64'd0);
        check("rst_valid", 64'(valid0), 64'd0);
        check("rst_ovf", 64'(ovf0), 64'd0);

        // first conversion after reset, no update pulse
        rst = 1'b0;
        run(32'd123456, 2'b00, 1'b0, n);
        check("udec_busy_cycles", 64'(n), 64'd34);
        check("udec_seg", 64'(seg0), 64'({S1, S2, S3, S4, S5, S6}));
        check("udec_model", 64'(m_seg0), 64'({S1, S2, S3, S4, S5, S6}));
        check("udec_valid", 64'(valid0), 64'd1);
        check("udec_ovf", 64'(ovf0), 64'd0);

        run(32'd1234567, 2'b00, 1'b0, n);
        check("udec_ovf_seg", 64'(seg0), 64'({S2, S3, S4, S5, S6, S7}));
        check("udec_ovf_flag", 64'(ovf0), 64'd1);

        run(32'hFFFF_FFD6, 2'b01, 1'b0, n);
        check("sdec_seg", 64'(seg0), 64'({SM, S0, S0, S0, S4, S2}));
        check("sdec_seg_blz", 64'(seg1), 64'({SM, SX, SX, SX, S4, S2}));
        check("sdec_model_blz", 64'(m_seg1), 64'({SM, SX, SX, SX, S4, S2}));
        check("sdec_ovf", 64'(ovf0), 64'd0);

        run(32'h8000_0000, 2'b01, 1'b0, n);   // most negative: magnitude 2147483648
        check("sdec_min_seg", 64'(seg0), 64'({SM, S8_fix(), S3, S6, S4, S8_fix()}));
        check("sdec_min_ovf", 64'(ovf0), 64'd1);

        run(32'hDEAD_BEEF, 2'b10, 1'b0, n);
        check("hex_latency", 64'(n), 64'd2);
        check("hex_seg", 64'(seg0), 64'({SA, SD, SB, SE, SE, SF}));
        check("hex_ovf", 64'(ovf0), 64'd1);

        run(32'h0000_00A0, 2'b10, 1'b0, n);
        check("hex_blz", 64'(seg1), 64'({SX, SX, SX, SX, SA, S0}));

        run(32'h8000_0000, 2'b11, 1'b0, n);
        check("flags_latency", 64'(n), 64'd2);
        check("flags_seg", 64'(seg0), 64'({S0, S0, S1, S0, S0, S0}));
        check("flags_seg_blz", 64'(seg1), 64'({S0, S0, S1, S0, S0, S0}));
        check("flags_ovf", 64'(ovf0), 64'd0);

        run(32'd7, 2'b00, 1'b0, n);
        check("udec_blz_small", 64'(seg1), 64'({SX, SX, SX, SX, SX, S7}));

        // value change during conversion: first result 10, then automatic reconversion to 11
        value = 32'd10; mode = 2'b00;
        cyc(1);
        cyc(4);
        value = 32'd11;
        wait_idle(n);
        check("chg_first_seg", 64'(seg0), 64'({S0, S0, S0, S0, S1, S0}));
        cyc(1);
        check("chg_rebusy", 64'(busy0), 64'd1);
        wait_idle(n);
        check("chg_final_seg", 64'(seg0), 64'({S0, S0, S0, S0, S1, S1}));

        // update with unchanged value retriggers
        run(32'd11, 2'b00, 1'b1, n);
        check("upd_busy_cycles", 64'(n), 64'd34);

        // reset mid-SHIFT aborts, then the held value converts on its own
        value = 32'd999999; mode = 2'b00;
        cyc(1);
        cyc(10);
        rst = 1'b1;
        cyc(1);
        check("abort_seg", 64'(seg0), 64'({SX, SX, SX, SX, SX, SX}));
        check("abort_busy", 64'(busy0), 64'd0);
        check("abort_valid", 64'(valid0), 64'd0);
        rst = 1'b0;
        cyc(1);
        check("abort_restart", 64'(busy0), 64'd1);
        wait_idle(n);
        check("abort_final_seg", 64'(seg0), 64'({S9, S9, S9, S9, S9, S9}));
        check("abort_final_valid", 64'(valid0), 64'd1);

        cyc(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    function automatic logic [6:0] S8_fix();
        return 7'b0000000;
    endfunction

endmodule
